// File: rtl/rgb_pwm_pkg.sv
// Shared types for the RGB PWM driver: buffer state and the duty triple payload.
package rgb_pwm_pkg;

    localparam int unsigned DUTY_W = 11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // Default-width triple as seen by the colour generator (PWM_INTERVAL = 1200).
    typedef struct packed {
        logic [DUTY_W-1:0] r;
        logic [DUTY_W-1:0] g;
        logic [DUTY_W-1:0] b;
    } duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: compares the shared period count against this channel's duty.
module pwm_channel #(
    parameter int unsigned DW         = 11,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] count,
    input  logic [DW-1:0] duty,
    output logic          led
);

    logic on_c;

    assign on_c = (count < duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= ACTIVE_LOW;
        end else begin
            led <= on_c ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel fixed-period PWM driver with double-buffered duty updates
// that only take effect on a period boundary.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned  PWM_INTERVAL = 1200,
    parameter bit           ACTIVE_LOW   = 1'b1,
    localparam int unsigned DW           = $clog2(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] duty_r,
    input  logic [DW-1:0] duty_g,
    input  logic [DW-1:0] duty_b,
    input  logic          duty_valid,
    output logic          duty_ready,
    output logic          led_r,
    output logic          led_g,
    output logic          led_b,
    output logic          period_start
);

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
    } triple_t;

    logic [DW-1:0] count;
    logic          wrap;
    logic          xfer;
    buf_state_t    state, state_nx;
    triple_t       active, active_nx;
    triple_t       pending, pending_nx;
    triple_t       duty_in;

    assign duty_in    = {duty_r, duty_g, duty_b};
    assign duty_ready = (state == EMPTY);
    assign xfer       = duty_valid & duty_ready;
    assign wrap       = (count == DW'(PWM_INTERVAL - 1));

    // Free-running period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            active       <= '0;
            pending      <= '0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nx;
            active       <= active_nx;
            pending      <= pending_nx;
            period_start <= (count == '0);
        end
    end

    // A triple arriving in the wrap cycle skips the buffer so it still lands next period.
    always_comb begin
        state_nx   = state;
        active_nx  = active;
        pending_nx = pending;
        case (state)
            EMPTY: begin
                if (xfer) begin
                    if (wrap) begin
                        active_nx = duty_in;
                    end else begin
                        pending_nx = duty_in;
                        state_nx   = FULL;
                    end
                end
            end
            FULL: begin
                if (wrap) begin
                    active_nx = pending;
                    state_nx  = EMPTY;
                end
            end
        endcase
    end

    pwm_channel #(.DW(DW), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .duty  (active.r),
        .led   (led_r)
    );

    pwm_channel #(.DW(DW), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .duty  (active.g),
        .led   (led_g)
    );

    pwm_channel #(.DW(DW), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .duty  (active.b),
        .led   (led_b)
    );

endmodule
